imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_array.sv | 31 +++
 rtl/imem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Misalignment wins over range so a bad PC is reported as such even if it is also out of range.
    function automatic fault_e classify_addr(input logic [31:0] addr, input int unsigned depth);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ({2'b00, addr[31:2]} >= 32'(depth)) begin
            return FAULT_RANGE;
        end
        return FAULT_OK;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are never reset, so a loaded program survives a core reset.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // A read and write to the same word in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: accepts one PC at a time, waits a
// fixed number of cycles, then holds the instruction until decode takes it.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_pc,
    output logic [1:0]    rsp_fault,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata
);

    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [31:0]   pc_q, pc_d;
    fault_e        fault_q, fault_d;
    fault_e        req_fault;
    logic          accept;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_data;

    assign req_fault = classify_addr(req_addr, DEPTH_WORDS);
    assign req_ready = ((state_q == IDLE) || ((state_q == RESP) && rsp_ready))
                       && !flush && !prog_we && !reset;
    assign accept    = req_valid && req_ready;

    // The array is read on the cycle that enters RESP, using the live address
    // for a zero-wait accept and the captured PC when leaving WAIT.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        rd_en   = 1'b0;
        rd_idx  = req_addr[AW+1:2];
        if (flush) begin
            state_d = IDLE;
            wait_d  = 4'd0;
        end else if (accept) begin
            pc_d    = req_addr;
            fault_d = req_fault;
            if ((WAIT_STATES > 0) && (req_fault == FAULT_OK)) begin
                state_d = WAIT;
                wait_d  = 4'(WAIT_STATES - 1);
            end else begin
                state_d = RESP;
                rd_en   = (req_fault == FAULT_OK);
            end
        end else begin
            case (state_q)
                WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_d = RESP;
                        rd_en   = 1'b1;
                        rd_idx  = pc_q[AW+1:2];
                    end else begin
                        wait_d = wait_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            pc_q    <= 32'd0;
            fault_q <= FAULT_OK;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .re_i    (rd_en),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

    // Outside a clean response the instruction bus shows a NOP, which also gives the reset value.
    assign rsp_valid = (state_q == RESP);
    assign rsp_instr = ((state_q == RESP) && (fault_q == FAULT_OK)) ? rd_data : NOP_INSTR;
    assign rsp_pc    = pc_q;
    assign rsp_fault = fault_q;

endmodule
